// File: rtl/apa102_frame_gen.sv
// APA102 frame sequencer: start frame, per-LED header/B/G/R, end frame,
// handed byte-by-byte to the SPI byte writer over a start/busy handshake.
module apa102_frame_gen #(
    parameter int NUM_LEDS    = 60,
    parameter int ADDR_W      = 8,
    parameter int END_BYTES   = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              strip_clk,
    input  logic              strip_reset_n,
    input  logic              frame_start,
    input  logic [4:0]        brightness,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_error,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    output logic              byte_start,
    output logic [7:0]        byte_data,
    input  logic              byte_busy
);

    localparam int BW = (END_BYTES > 4) ? $clog2(END_BYTES) : 2;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [BW-1:0]     GRP_LAST = BW'(3);
    localparam logic [BW-1:0]     END_LAST = BW'(END_BYTES - 1);
    localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(NUM_LEDS - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        PH_START,
        PH_LED,
        PH_END
    } phase_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FETCH,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t            state;
    phase_t            phase;
    logic [BW-1:0]     byte_idx;
    logic [ADDR_W-1:0] led_idx;
    logic [TW-1:0]     tmo_cnt;
    logic [23:0]       pix_q;
    logic [4:0]        bright_q;
    logic [7:0]        next_byte;
    logic              grp_last;

    assign grp_last = (byte_idx == GRP_LAST);

    always_comb begin
        next_byte = 8'h00;
        unique case (1'b1)
            (phase == PH_LED && byte_idx == BW'(0)):
                next_byte = {3'b111, bright_q};
            (phase == PH_LED && byte_idx == BW'(1)):
                next_byte = pix_q[7:0];
            (phase == PH_LED && byte_idx == BW'(2)):
                next_byte = pix_q[15:8];
            (phase == PH_LED && byte_idx == BW'(3)):
                next_byte = pix_q[23:16];
            (phase == PH_END):
                next_byte = 8'hFF;
            default:
                next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge strip_clk or negedge strip_reset_n) begin
        if (!strip_reset_n) begin
            state       <= S_IDLE;
            phase       <= PH_START;
            byte_idx    <= '0;
            led_idx     <= '0;
            tmo_cnt     <= '0;
            pix_q       <= '0;
            bright_q    <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            pix_rd      <= 1'b0;
            pix_addr    <= '0;
            byte_start  <= 1'b0;
            byte_data   <= '0;
        end else begin
            pix_rd     <= 1'b0;
            byte_start <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        bright_q    <= brightness;
                        frame_error <= 1'b0;
                        frame_busy  <= 1'b1;
                        phase       <= PH_START;
                        byte_idx    <= '0;
                        state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (phase == PH_LED && byte_idx == '0) begin
                        pix_rd   <= 1'b1;
                        pix_addr <= led_idx;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_FETCH: begin
                    // first FETCH cycle carries the strobe; RAM data lands one later
                    if (!pix_rd) begin
                        pix_q <= pix_data;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    byte_data  <= next_byte;
                    byte_start <= 1'b1;
                    tmo_cnt    <= '0;
                    state      <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (byte_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_error <= 1'b1;
                        frame_busy  <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!byte_busy) begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    unique case (1'b1)
                        (phase == PH_START && grp_last): begin
                            phase    <= PH_LED;
                            led_idx  <= '0;
                            byte_idx <= '0;
                            state    <= S_SELECT;
                        end
                        (phase == PH_LED && grp_last &&
                         led_idx == LED_LAST): begin
                            phase    <= PH_END;
                            byte_idx <= '0;
                            state    <= S_SELECT;
                        end
                        (phase == PH_LED && grp_last &&
                         led_idx != LED_LAST): begin
                            led_idx  <= led_idx + 1'b1;
                            byte_idx <= '0;
                            state    <= S_SELECT;
                        end
                        (phase == PH_END && byte_idx == END_LAST): begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                        default: begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= S_SELECT;
                        end
                    endcase
                end
                S_DONE: begin
                    frame_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
